// File: rtl/branch_resolve_tracker_if.sv
// Fetch/execute side of the branch resolve tracker:
// prediction record, resolution and flush.
interface branch_resolve_tracker_if;
  logic        pred_val;
  logic        pred_rdy;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        resolve_val;
  logic        resolve_rdy;
  logic        resolve_taken;
  logic        flush;

  modport master (
    output pred_val,
    output pred_pc,
    output pred_taken,
    output resolve_val,
    output resolve_taken,
    output flush,
    input  pred_rdy,
    input  resolve_rdy
  );

  modport slave (
    input  pred_val,
    input  pred_pc,
    input  pred_taken,
    input  resolve_val,
    input  resolve_taken,
    input  flush,
    output pred_rdy,
    output resolve_rdy
  );
endinterface

// File: rtl/branch_resolve_tracker.sv
// In-order queue of fetch-time branch predictions; drives the
// PHT update port one cycle after execute resolves the oldest.
module branch_resolve_tracker #(
  parameter  int p_num_entries = 4,
  localparam int c_addr_nbits  = $clog2(p_num_entries)
) (
  input  logic        clk,
  input  logic        reset,
  branch_resolve_tracker_if.slave bus,
  output logic        upd_en,
  output logic        upd_taken,
  output logic [31:0] upd_pc,
  output logic        mispredict,
  output logic [31:0] num_branches,
  output logic [31:0] num_mispredicts
);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } entry_t;

  localparam logic [c_addr_nbits:0] c_full =
    (c_addr_nbits+1)'(p_num_entries);

  entry_t                  q [p_num_entries];
  logic [c_addr_nbits-1:0] head;
  logic [c_addr_nbits-1:0] tail;
  logic [c_addr_nbits:0]   count;

  logic   enq;
  logic   deq;
  logic   miss;
  entry_t head_e;

  assign bus.pred_rdy    = (count != c_full);
  assign bus.resolve_rdy = (count != '0);

  assign enq = bus.pred_val & bus.pred_rdy & ~bus.flush;
  assign deq = bus.resolve_val & bus.resolve_rdy;

  assign head_e = q[head];
  assign miss   = head_e.taken != bus.resolve_taken;

  // Payload storage needs no reset; count guards validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      q[tail] <= '{pc: bus.pred_pc, taken: bus.pred_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A dequeue in a flush cycle still reports its outcome.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_en          <= 1'b0;
      upd_taken       <= 1'b0;
      upd_pc          <= '0;
      mispredict      <= 1'b0;
      num_branches    <= '0;
      num_mispredicts <= '0;
    end else begin
      upd_en     <= deq;
      mispredict <= deq & miss;
      if (deq) begin
        upd_pc       <= head_e.pc;
        upd_taken    <= bus.resolve_taken;
        num_branches <= num_branches + 32'd1;
        if (miss) begin
          num_mispredicts <= num_mispredicts + 32'd1;
        end
      end
    end
  end

endmodule

// File: doc/branch_resolve_tracker.md
Name: branch_resolve_tracker

Overview:
- Companion to the bimodal PHT predictor; sits between fetch and execute.
- Records each branch prediction made at fetch (PC plus predicted direction) in an in-order queue.
- When execute resolves the oldest branch, the block drives the predictor's update interface (update_en, update_val, PC) one cycle later and flags a mispredict.
- Maintains running branch and mispredict counters for evaluating predictors.

Parameters:
- p_num_entries, 4, in-flight prediction queue depth; power of two, >= 2.
- c_addr_nbits, $clog2(p_num_entries), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- pred_val  in  1  fetch has a prediction to record
- pred_rdy  out  1  queue can accept a prediction
- pred_pc  in  32  PC of the predicted branch
- pred_taken  in  1  predicted direction (predictor's prediction output)
- resolve_val  in  1  execute has resolved the oldest branch
- resolve_rdy  out  1  a recorded prediction is available to match
- resolve_taken  in  1  actual branch outcome
- flush  in  1  squash all recorded, unresolved predictions
- upd_en  out  1  predictor update strobe (to update_en)
- upd_taken  out  1  actual outcome (to update_val)
- upd_pc  out  32  PC to update (muxed onto predictor PC)
- mispredict  out  1  qualified by upd_en; predicted != actual
- num_branches  out  32  resolved-branch count
- num_mispredicts  out  32  mispredict count

Behaviour:
- Reset: synchronous, active-high; clock clk.
  - Queue empty; head/tail pointers and count 0.
  - upd_en=0, upd_taken=0, upd_pc=0, mispredict=0, num_branches=0, num_mispredicts=0.
  - pred_rdy=1 and resolve_rdy=0 in the first cycle after reset.
  - Reset mid-operation discards all entries; no update is issued for them.
- Storage: queue entry = {pc[31:0], pred_taken}. Pointers wrap modulo p_num_entries. count width c_addr_nbits+1.
- pred_rdy = (count != p_num_entries), combinational from state only. No full bypass: a dequeue in the same cycle does not raise pred_rdy.
- resolve_rdy = (count != 0), combinational from state only. No empty bypass: a prediction enqueued in cycle N cannot be resolved before cycle N+1.
- Enqueue fire (pred_val && pred_rdy && !flush): write the entry at tail; tail++.
- Dequeue fire (resolve_val && resolve_rdy): read the entry at head; head++.
- Simultaneous enqueue and dequeue: both happen; count unchanged.
- Update output, registered with 1-cycle latency:
  - In the cycle after a dequeue fire: upd_en=1, upd_pc=head.pc, upd_taken=resolve_taken, mispredict=(head.pred_taken != resolve_taken).
  - Otherwise upd_en=0 and mispredict=0. upd_pc and upd_taken hold their last values.
  - Back-to-back dequeues give back-to-back upd_en pulses.
- Counters: registered on the same edge as the upd_* outputs, so new values are visible in the upd_en cycle.
  - num_branches += 1 per dequeue fire.
  - num_mispredicts += 1 per mispredicting dequeue fire.
  - Both wrap modulo 2^32.
- flush:
  - At the next edge: count=0 and head=tail=0.
  - A dequeue fire in the same cycle is still honoured: its update, mispredict and counter increments are produced normally. This covers the mispredicting branch that triggers the flush.
  - An enqueue in the flush cycle is dropped; pred_rdy is unaffected by flush.
- Protocol violations (resolve_val while resolve_rdy=0, pred_val while pred_rdy=0) have no effect on state.

Test Plan:
- Reset, then one enqueue (pc=0x100, taken=1) in cycle 1 and resolve_taken=1 in cycle 2 -> cycle 3: upd_en=1, upd_pc=0x100, upd_taken=1, mispredict=0, num_branches=1, num_mispredicts=0.
- Enqueue pcs 0x200 (pred 0), 0x204 (pred 1), then resolve with taken 1 and 1 on consecutive cycles -> two consecutive upd_en pulses in order 0x200 then 0x204; mispredict 1 then 0; num_mispredicts=1.
- Fill 4 entries (0x300..0x30C) -> pred_rdy=0. A 5th pred_val is ignored. Resolve once -> pred_rdy=1 next cycle. Drain all -> PCs emerge 0x300, 0x304, 0x308, 0x30C, exercising pointer wrap.
- Full queue with pred_val=1 and resolve_val=1 in the same cycle -> dequeue only, count 3. At count=2, simultaneous enqueue and dequeue -> count stays 2, FIFO order preserved.
- Three entries; resolve head with mispredict while flush=1 and pred_val=1 -> next cycle upd_en=1, mispredict=1, resolve_rdy=0, count 0, new prediction dropped.
- Reset asserted with 2 entries queued and a pending update -> next cycle upd_en=0, resolve_rdy=0, both counters 0.
